othello_judge: RTL

- Game-flow judge directly downstream of the registered black/red piece counter.
- Consumes `cntB`/`cntR` after every applied move or pass. Tracks the player to move, consecutive passes and the move number.
- Detects end of game (board full, one colour eliminated, two consecutive passes) and latches winner and margin for the display and score logic.

---
 rtl/othello_judge.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/othello_judge.sv
// othello_judge: game-flow judge sitting after the registered black/red piece counter.
// Tracks the side to move, consecutive passes and the move number, waits for the piece
// counts to settle after each update, then decides whether the game has ended and
// latches the winner and margin.
//
// Ports:
//   clk          system clock, rising edge
//   RST          asynchronous active-low reset
//   start        pulse: begin a new game (highest priority, aborts a running game)
//   turn_done    pulse: current player's move written to the boards
//   pass         pulse: current player has no legal move
//   cntB, cntR   registered black / red piece counts
//   turn         side to move (0 black, 1 red)
//   move_num     applied moves this game, saturating at 127
//   busy         high in SETTLE and CHECK; no turn_done/pass may be issued
//   game_over    high in DONE
//   winner       00 none, 01 black, 10 red, 11 draw
//   margin       |cntB - cntR| latched at game end
//   result_valid one-cycle pulse on entry to DONE
//   timeout      (JUDGE_TIMER_EN only) side to move forfeited on the turn timer
//
// Optional feature: define JUDGE_TIMER_EN to add the per-turn forfeit timer and the
// timeout output.
module othello_judge #(
    parameter int unsigned BOARD_CELLS  = 64,
    parameter int unsigned CNT_LAT      = 1,
    parameter logic [23:0] TURN_TIMEOUT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic       turn_done,
    input  logic       pass,
    input  logic [7:0] cntB,
    input  logic [7:0] cntR,
    output logic       turn,
    output logic [6:0] move_num,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [6:0] margin,
    output logic       result_valid
`ifdef JUDGE_TIMER_EN
    ,
    output logic       timeout
`endif
);

    localparam int unsigned SettleW = (CNT_LAT > 1) ? $clog2(CNT_LAT) : 1;
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(CNT_LAT - 1);

    typedef enum logic [2:0] {StIdle, StPlay, StSettle, StCheck, StDone} state_e;

    state_e             stateQ, stateD;
    logic               turnQ, turnD;
    logic [6:0]         moveNumQ, moveNumD;
    logic [1:0]         passCntQ, passCntD;
    logic [SettleW-1:0] settleCntQ, settleCntD;
    logic [1:0]         winnerQ, winnerD;
    logic [6:0]         marginQ, marginD;
    logic               resultValidQ, resultValidD;

    logic [8:0] sum;
    logic       endCond;
    logic [1:0] resWinner;
    logic [6:0] resMargin;

    // Difference never exceeds the board size, so 7 bits of it are enough.
    assign sum       = {1'b0, cntB} + {1'b0, cntR};
    assign endCond   = (sum >= 9'(BOARD_CELLS)) || (cntB == 8'd0) || (cntR == 8'd0) ||
                       (passCntQ == 2'd2);
    assign resWinner = (cntB > cntR) ? 2'b01 : ((cntR > cntB) ? 2'b10 : 2'b11);
    assign resMargin = (cntB >= cntR) ? 7'(cntB - cntR) : 7'(cntR - cntB);

`ifdef JUDGE_TIMER_EN
    logic [23:0] timerQ, timerD;
    logic        timeoutQ, timeoutD;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            timerQ   <= '0;
            timeoutQ <= 1'b0;
        end else begin
            timerQ   <= timerD;
            timeoutQ <= timeoutD;
        end
    end

    assign timeout = timeoutQ;
`else
    logic unusedTimeoutParam;
    assign unusedTimeoutParam = ^TURN_TIMEOUT;
`endif

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            stateQ       <= StIdle;
            turnQ        <= 1'b0;
            moveNumQ     <= '0;
            passCntQ     <= '0;
            settleCntQ   <= '0;
            winnerQ      <= '0;
            marginQ      <= '0;
            resultValidQ <= 1'b0;
        end else begin
            stateQ       <= stateD;
            turnQ        <= turnD;
            moveNumQ     <= moveNumD;
            passCntQ     <= passCntD;
            settleCntQ   <= settleCntD;
            winnerQ      <= winnerD;
            marginQ      <= marginD;
            resultValidQ <= resultValidD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        turnD        = turnQ;
        moveNumD     = moveNumQ;
        passCntD     = passCntQ;
        settleCntD   = settleCntQ;
        winnerD      = winnerQ;
        marginD      = marginQ;
        resultValidD = 1'b0;
`ifdef JUDGE_TIMER_EN
        timerD       = timerQ;
        timeoutD     = timeoutQ;
`endif

        unique case (stateQ)
            StIdle: ;
            StPlay: begin
                // turn_done wins over a simultaneous pass.
                if (turn_done) begin
                    turnD      = ~turnQ;
                    passCntD   = 2'd0;
                    settleCntD = SettleLoad;
                    stateD     = StSettle;
                    if (moveNumQ != 7'd127) moveNumD = moveNumQ + 7'd1;
`ifdef JUDGE_TIMER_EN
                    timerD     = '0;
`endif
                end else if (pass) begin
                    turnD    = ~turnQ;
                    passCntD = passCntQ + 2'd1;
                    if (passCntQ == 2'd1) begin
                        settleCntD = SettleLoad;
                        stateD     = StSettle;
                    end
`ifdef JUDGE_TIMER_EN
                    timerD   = '0;
                end else if (timerQ == TURN_TIMEOUT - 24'd1) begin
                    // Side to move forfeits; opponent wins.
                    stateD       = StDone;
                    winnerD      = turnQ ? 2'b01 : 2'b10;
                    marginD      = '0;
                    timeoutD     = 1'b1;
                    resultValidD = 1'b1;
                end else begin
                    timerD = timerQ + 24'd1;
`endif
                end
            end
            StSettle: begin
                if (settleCntQ == '0) stateD = StCheck;
                else settleCntD = settleCntQ - SettleW'(1);
            end
            StCheck: begin
                if (endCond) begin
                    stateD       = StDone;
                    winnerD      = resWinner;
                    marginD      = resMargin;
                    resultValidD = 1'b1;
                end else begin
                    stateD = StPlay;
`ifdef JUDGE_TIMER_EN
                    timerD = '0;
`endif
                end
            end
            StDone: ;
            default: stateD = StIdle;
        endcase

        // start overrides everything and never produces a result for an aborted game.
        if (start) begin
            stateD       = StPlay;
            turnD        = 1'b0;
            moveNumD     = '0;
            passCntD     = '0;
            settleCntD   = '0;
            winnerD      = '0;
            marginD      = '0;
            resultValidD = 1'b0;
`ifdef JUDGE_TIMER_EN
            timerD       = '0;
            timeoutD     = 1'b0;
`endif
        end
    end

    assign turn         = turnQ;
    assign move_num     = moveNumQ;
    assign busy         = (stateQ == StSettle) || (stateQ == StCheck);
    assign game_over    = (stateQ == StDone);
    assign winner       = winnerQ;
    assign margin       = marginQ;
    assign result_valid = resultValidQ;

endmodule
